// File: rtl/uni_pkg.sv
// rtl/uni_pkg.sv - shared uni_if constants and arbiter state type
package uni_pkg;

  localparam logic UNI_RD = 1'b0;
  localparam logic UNI_WR = 1'b1;

  localparam logic [1:0] UNI_B = 2'd0;
  localparam logic [1:0] UNI_H = 2'd1;
  localparam logic [1:0] UNI_W = 2'd2;
  localparam logic [1:0] UNI_D = 2'd3;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // One-hot grant bit positions
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uni_arb_pick.sv
// rtl/uni_arb_pick.sv - 2-way grant picker; ARB_RR_EN selects round-robin
module uni_arb_pick
  import uni_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       last_lsu,
  output logic [1:0] grant
);

`ifdef ARB_RR_EN
  // Round-robin: on contention the master that did not win last time goes
  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      if (last_lsu) grant[GNT_IFU] = 1'b1;
      else          grant[GNT_LSU] = 1'b1;
    end else begin
      grant[GNT_IFU] = ifu_valid;
      grant[GNT_LSU] = lsu_valid;
    end
  end
`else
  // The last-grant flag has no meaning under fixed priority
  logic unused_last;
  assign unused_last = last_lsu;

  // Fixed priority: LSU wins over IFU to keep load/store ordering
  always_comb begin
    grant          = 2'b00;
    grant[GNT_LSU] = lsu_valid;
    grant[GNT_IFU] = ifu_valid & ~lsu_valid;
  end
`endif

endmodule

// File: rtl/uni_arb2.sv
// rtl/uni_arb2.sv - registered IFU/LSU arbiter onto one uni_if slave (ARB_RR_EN: round-robin)
module uni_arb2
  import uni_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ifu_valid,
  input  logic              i_ifu_reqtyp,
  input  logic [ADDR_W-1:0] i_ifu_addr,
  input  logic [DATA_W-1:0] i_ifu_wdata,
  input  logic [1:0]        i_ifu_size,
  output logic              o_ifu_ready,
  output logic [DATA_W-1:0] o_ifu_rdata,
  output logic [1:0]        o_ifu_resp,
  input  logic              i_lsu_valid,
  input  logic              i_lsu_reqtyp,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic [1:0]        i_lsu_size,
  output logic              o_lsu_ready,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic [1:0]        o_lsu_resp,
  output logic              o_valid,
  output logic              o_reqtyp,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [1:0]        o_size,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_resp
);

  arb_state_t state;
  logic [1:0] grant;
  logic       last_lsu;
  logic       ifu_done;
  logic       lsu_done;

  uni_arb_pick u_pick (
    .ifu_valid (i_ifu_valid),
    .lsu_valid (i_lsu_valid),
    .last_lsu  (last_lsu),
    .grant     (grant)
  );

`ifdef ARB_RR_EN
  // Remember who won the most recent grant; reset favours LSU next
  always_ff @(posedge i_clk) begin
    if (i_rst)
      last_lsu <= 1'b0;
    else if (state == IDLE && grant != 2'b00)
      last_lsu <= grant[GNT_LSU];
  end
`else
  assign last_lsu = 1'b0;
`endif

  // Arbiter FSM: latch the winner's request and hold it until the slave completes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_reqtyp <= UNI_RD;
      o_addr   <= '0;
      o_wdata  <= '0;
      o_size   <= UNI_B;
    end else begin
      case (state)
        IDLE: begin
          if (grant[GNT_LSU]) begin
            state    <= BUSY_LSU;
            o_valid  <= 1'b1;
            o_reqtyp <= i_lsu_reqtyp;
            o_addr   <= i_lsu_addr;
            o_wdata  <= i_lsu_wdata;
            o_size   <= i_lsu_size;
          end else if (grant[GNT_IFU]) begin
            state    <= BUSY_IFU;
            o_valid  <= 1'b1;
            o_reqtyp <= i_ifu_reqtyp;
            o_addr   <= i_ifu_addr;
            o_wdata  <= i_ifu_wdata;
            o_size   <= i_ifu_size;
          end
        end
        BUSY_IFU, BUSY_LSU: begin
          // Master valid is deliberately ignored here: a dropped valid still completes
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  // Route the slave response only to the granted master; everything else reads zero
  always_comb begin
    ifu_done    = (state == BUSY_IFU) && i_ready;
    lsu_done    = (state == BUSY_LSU) && i_ready;
    o_ifu_ready = ifu_done;
    o_ifu_rdata = ifu_done ? i_rdata : '0;
    o_ifu_resp  = ifu_done ? i_resp : OKAY;
    o_lsu_ready = lsu_done;
    o_lsu_rdata = lsu_done ? i_rdata : '0;
    o_lsu_resp  = lsu_done ? i_resp : OKAY;
  end

endmodule

// File: tb/tb_uni_arb2.sv
// tb/tb_uni_arb2.sv - self-checking bench for uni_arb2
module tb_uni_arb2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ifu_valid, i_ifu_reqtyp;
  logic [63:0] i_ifu_addr, i_ifu_wdata;
  logic [1:0]  i_ifu_size;
  logic        o_ifu_ready;
  logic [63:0] o_ifu_rdata;
  logic [1:0]  o_ifu_resp;
  logic        i_lsu_valid, i_lsu_reqtyp;
  logic [63:0] i_lsu_addr, i_lsu_wdata;
  logic [1:0]  i_lsu_size;
  logic        o_lsu_ready;
  logic [63:0] o_lsu_rdata;
  logic [1:0]  o_lsu_resp;
  logic        o_valid, o_reqtyp;
  logic [63:0] o_addr, o_wdata;
  logic [1:0]  o_size;
  logic        i_ready;
  logic [63:0] i_rdata;
  logic [1:0]  i_resp;

  int n_checks = 0;
  int n_fail   = 0;
  logic last_lsu_m = 1'b0;

  always #5 i_clk = ~i_clk;

  uni_arb2 #(.ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ifu_valid(i_ifu_valid), .i_ifu_reqtyp(i_ifu_reqtyp), .i_ifu_addr(i_ifu_addr),
    .i_ifu_wdata(i_ifu_wdata), .i_ifu_size(i_ifu_size),
    .o_ifu_ready(o_ifu_ready), .o_ifu_rdata(o_ifu_rdata), .o_ifu_resp(o_ifu_resp),
    .i_lsu_valid(i_lsu_valid), .i_lsu_reqtyp(i_lsu_reqtyp), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_size(i_lsu_size),
    .o_lsu_ready(o_lsu_ready), .o_lsu_rdata(o_lsu_rdata), .o_lsu_resp(o_lsu_resp),
    .o_valid(o_valid), .o_reqtyp(o_reqtyp), .o_addr(o_addr), .o_wdata(o_wdata), .o_size(o_size),
    .i_ready(i_ready), .i_rdata(i_rdata), .i_resp(i_resp)
  );

  typedef struct {
    logic        ifu_v;
    logic        ifu_typ;
    logic [63:0] ifu_addr;
    logic [63:0] ifu_wdata;
    logic [1:0]  ifu_size;
    logic        lsu_v;
    logic        lsu_typ;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [1:0]  lsu_size;
    int          lat;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic        exp_lsu;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ifu_valid = 0; i_ifu_reqtyp = 0; i_ifu_addr = 0; i_ifu_wdata = 0; i_ifu_size = 0;
    i_lsu_valid = 0; i_lsu_reqtyp = 0; i_lsu_addr = 0; i_lsu_wdata = 0; i_lsu_size = 0;
    i_ready = 0; i_rdata = 0; i_resp = 0;
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1;
    for (int i = 0; i < cycles; i++) tick();
    i_rst = 0;
    last_lsu_m = 1'b0;
  endtask

  // Expected winner: table value under fixed priority, round-robin model otherwise
  function automatic logic exp_winner(input vec_t v);
`ifdef ARB_RR_EN
    if (v.ifu_v && v.lsu_v) return ~last_lsu_m;
    return v.lsu_v;
`else
    return v.exp_lsu;
`endif
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic w;
    w = exp_winner(v);
    i_ifu_valid = v.ifu_v; i_ifu_reqtyp = v.ifu_typ; i_ifu_addr = v.ifu_addr;
    i_ifu_wdata = v.ifu_wdata; i_ifu_size = v.ifu_size;
    i_lsu_valid = v.lsu_v; i_lsu_reqtyp = v.lsu_typ; i_lsu_addr = v.lsu_addr;
    i_lsu_wdata = v.lsu_wdata; i_lsu_size = v.lsu_size;
    tick();
    chk($sformatf("v%0d o_valid", idx), o_valid, 1);
    chk($sformatf("v%0d o_reqtyp", idx), o_reqtyp, w ? v.lsu_typ : v.ifu_typ);
    chk($sformatf("v%0d o_addr", idx), o_addr, w ? v.lsu_addr : v.ifu_addr);
    chk($sformatf("v%0d o_wdata", idx), o_wdata, w ? v.lsu_wdata : v.ifu_wdata);
    chk($sformatf("v%0d o_size", idx), o_size, w ? v.lsu_size : v.ifu_size);
    for (int i = 1; i < v.lat; i++) begin
      tick();
      chk($sformatf("v%0d wait ready", idx), {o_ifu_ready, o_lsu_ready, o_valid}, 3'b001);
    end
    i_ready = 1; i_rdata = v.rdata; i_resp = v.resp;
    #1;
    chk($sformatf("v%0d ifu_ready", idx), o_ifu_ready, !w);
    chk($sformatf("v%0d lsu_ready", idx), o_lsu_ready, w);
    chk($sformatf("v%0d ifu_rdata", idx), o_ifu_rdata, w ? 64'h0 : v.rdata);
    chk($sformatf("v%0d lsu_rdata", idx), o_lsu_rdata, w ? v.rdata : 64'h0);
    chk($sformatf("v%0d ifu_resp", idx), o_ifu_resp, w ? 2'd0 : v.resp);
    chk($sformatf("v%0d lsu_resp", idx), o_lsu_resp, w ? v.resp : 2'd0);
    last_lsu_m = w;
    tick();
    idle_inputs();
    #1;
    chk($sformatf("v%0d o_valid after done", idx), o_valid, 0);
    tick();
    chk($sformatf("v%0d stays idle", idx), o_valid, 0);
  endtask

  initial begin
    logic exp_l;
    vecs[0] = '{1, 0, 64'h8000_0000, 64'h0, 2'd2, 0, 0, 64'h0, 64'h0, 2'd0, 3, 64'h13, 2'd0, 0};
    vecs[1] = '{0, 0, 64'h0, 64'h0, 2'd0, 1, 1, 64'h8000_1000, 64'hDEAD_BEEF, 2'd3, 1, 64'h0, 2'd0, 1};
    vecs[2] = '{1, 0, 64'h8000_0004, 64'h0, 2'd2, 1, 0, 64'h2000, 64'h0, 2'd1, 2, 64'h1234, 2'd1, 1};
    vecs[3] = '{1, 1, 64'h40, 64'hA5, 2'd0, 0, 0, 64'h0, 64'h0, 2'd0, 1, 64'h0, 2'd2, 0};
    vecs[4] = '{1, 0, 64'h8000_0008, 64'h0, 2'd2, 1, 1, 64'h3008, 64'hCAFE, 2'd3, 4, 64'h55AA, 2'd3, 1};

    idle_inputs();
    do_reset(3);
    chk("reset o_valid", o_valid, 0);
    chk("reset o_fields", {o_reqtyp, o_size} , 3'b000);
    chk("reset o_addr", o_addr, 0);
    chk("reset o_wdata", o_wdata, 0);
    chk("reset readies", {o_ifu_ready, o_lsu_ready}, 2'b00);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Simultaneous request: LSU first, IFU issued two cycles after LSU completion
    do_reset(2);
    i_ifu_valid = 1; i_ifu_addr = 64'h8000_0004; i_ifu_size = 2'd2;
    i_lsu_valid = 1; i_lsu_reqtyp = 1; i_lsu_addr = 64'h8000_1000;
    i_lsu_wdata = 64'hDEAD_BEEF; i_lsu_size = 2'd3;
    tick();
    chk("sim first reqtyp", o_reqtyp, 1);
    chk("sim first wdata", o_wdata, 64'hDEAD_BEEF);
    tick(); tick();
    i_ready = 1;
    #1;
    chk("sim lsu ready", {o_ifu_ready, o_lsu_ready}, 2'b01);
    tick();
    i_ready = 0; i_lsu_valid = 0;
    #1;
    chk("sim gap cycle", o_valid, 0);
    tick();
    chk("sim second valid", o_valid, 1);
    chk("sim second addr", o_addr, 64'h8000_0004);
    chk("sim second reqtyp", o_reqtyp, 0);
    i_ready = 1;
    #1;
    chk("sim ifu ready", {o_ifu_ready, o_lsu_ready}, 2'b10);
    tick();
    idle_inputs();
    tick();

    // Both masters continuously valid for four transactions
    last_lsu_m = 1'b0;
    i_ifu_valid = 1; i_ifu_addr = 64'hA000;
    i_lsu_valid = 1; i_lsu_addr = 64'hB000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_l = (k % 2 == 0);
`else
      exp_l = 1'b1;
`endif
      tick();
      chk($sformatf("cont%0d addr", k), o_addr, exp_l ? 64'hB000 : 64'hA000);
      i_ready = 1;
      #1;
      chk($sformatf("cont%0d ready", k), {o_ifu_ready, o_lsu_ready}, exp_l ? 2'b01 : 2'b10);
      tick();
      i_ready = 0;
    end
    idle_inputs();
    tick();

    // Valid dropped while granted: request held to completion
    i_ifu_valid = 1; i_ifu_addr = 64'h100; i_ifu_size = 2'd3;
    tick();
    i_ifu_valid = 0;
    tick(); tick();
    chk("drop o_valid held", o_valid, 1);
    chk("drop o_addr held", o_addr, 64'h100);
    chk("drop no early ready", o_ifu_ready, 0);
    i_ready = 1; i_rdata = 64'h77;
    #1;
    chk("drop ifu ready", o_ifu_ready, 1);
    chk("drop ifu rdata", o_ifu_rdata, 64'h77);
    tick();
    idle_inputs();
    #1;
    chk("drop back idle", o_valid, 0);
    tick();
    chk("drop stays idle", o_valid, 0);

    // Reset in the middle of an LSU transaction
    i_lsu_valid = 1; i_lsu_addr = 64'h200;
    tick();
    chk("rst mid granted", o_valid, 1);
    i_lsu_valid = 0;
    do_reset(1);
    i_ready = 1; i_resp = 2'd1;
    #1;
    chk("rst mid o_valid", o_valid, 0);
    chk("rst mid no ready", {o_ifu_ready, o_lsu_ready}, 2'b00);
    i_ready = 0; i_resp = 0;
    i_ifu_valid = 1; i_ifu_addr = 64'h300;
    tick();
    chk("rst mid regrant valid", o_valid, 1);
    chk("rst mid regrant addr", o_addr, 64'h300);
    i_ready = 1;
    #1;
    chk("rst mid regrant ready", {o_ifu_ready, o_lsu_ready}, 2'b10);
    tick();
    idle_inputs();
    tick();

    // Stray slave ready in IDLE
    i_ready = 1; i_resp = 2'd2; i_rdata = 64'hFF;
    #1;
    chk("stray no ready", {o_ifu_ready, o_lsu_ready}, 2'b00);
    chk("stray resp", {o_ifu_resp, o_lsu_resp}, 4'h0);
    chk("stray rdata", o_ifu_rdata | o_lsu_rdata, 64'h0);
    tick();
    i_ready = 0; i_resp = 0; i_rdata = 0;
    #1;
    chk("stray stays idle", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
